// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types and defaults for the AXI read-path arbiter.
// The slave-side ID is widened by the master-select bits.
package axi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } rd_state_e;

  localparam int NUM_M_DEF     = 2;
  localparam int IDM_BITS_DEF  = 4;
  localparam int ADDR_BITS_DEF = 32;
  localparam int DATA_BITS_DEF = 32;
  localparam int LEN_BITS_DEF  = 4;
  localparam int SIZE_BITS_DEF = 3;

  function automatic int ids_bits(input int num_m, input int idm_bits);
    return $clog2(num_m) + idm_bits;
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_rr_pick.sv
// Combinational round-robin select: the first requester strictly after
// `last`, wrapping from NUM_M-1 back to 0.
module rr_pick
  import axi_pkg::*;
#(
  parameter int NUM_M = NUM_M_DEF,
  localparam int SEL_BITS = $clog2(NUM_M)
) (
  input  logic [NUM_M-1:0]    req,
  input  logic [SEL_BITS-1:0] last,
  output logic [SEL_BITS-1:0] grant,
  output logic                any_req
);

  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    // Scan farthest-first so the nearest requester after `last` wins.
    for (int k = NUM_M; k >= 1; k--) begin
      if (req[(int'(last) + k) % NUM_M]) begin
        grant   = SEL_BITS'((int'(last) + k) % NUM_M);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Read-path arbiter: NUM_M masters share one slave AR/R pair with one burst
// in flight, round-robin grant, master index prepended to ARID, beat-count check.
module axi_rd_arbiter
  import axi_pkg::*;
#(
  parameter int NUM_M     = NUM_M_DEF,
  parameter int IDM_BITS  = IDM_BITS_DEF,
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int LEN_BITS  = LEN_BITS_DEF,
  parameter int SIZE_BITS = SIZE_BITS_DEF,
  localparam int SEL_BITS = $clog2(NUM_M),
  localparam int IDS_BITS = ids_bits(NUM_M, IDM_BITS)
) (
  input  logic                                 ACLK,
  input  logic                                 ARESETn,
  input  logic [NUM_M-1:0][IDM_BITS-1:0]       ARID_M,
  input  logic [NUM_M-1:0][ADDR_BITS-1:0]      ARADDR_M,
  input  logic [NUM_M-1:0][LEN_BITS-1:0]       ARLEN_M,
  input  logic [NUM_M-1:0][SIZE_BITS-1:0]      ARSIZE_M,
  input  logic [NUM_M-1:0][1:0]                ARBURST_M,
  input  logic [NUM_M-1:0]                     ARVALID_M,
  output logic [NUM_M-1:0]                     ARREADY_M,
  output logic [NUM_M-1:0][IDM_BITS-1:0]       RID_M,
  output logic [NUM_M-1:0][DATA_BITS-1:0]      RDATA_M,
  output logic [NUM_M-1:0][1:0]                RRESP_M,
  output logic [NUM_M-1:0]                     RLAST_M,
  output logic [NUM_M-1:0]                     RVALID_M,
  input  logic [NUM_M-1:0]                     RREADY_M,
  output logic [IDS_BITS-1:0]                  ARID_S,
  output logic [ADDR_BITS-1:0]                 ARADDR_S,
  output logic [LEN_BITS-1:0]                  ARLEN_S,
  output logic [SIZE_BITS-1:0]                 ARSIZE_S,
  output logic [1:0]                           ARBURST_S,
  output logic                                 ARVALID_S,
  input  logic                                 ARREADY_S,
  input  logic [IDS_BITS-1:0]                  RID_S,
  input  logic [DATA_BITS-1:0]                 RDATA_S,
  input  logic [1:0]                           RRESP_S,
  input  logic                                 RLAST_S,
  input  logic                                 RVALID_S,
  output logic                                 RREADY_S,
  output logic                                 LEN_ERR
);

  rd_state_e           state, state_nxt;
  logic [SEL_BITS-1:0] grant, grant_nxt;
  logic [SEL_BITS-1:0] last_grant, last_nxt;
  logic [SEL_BITS-1:0] pick_idx;
  logic                pick_any;
  logic [LEN_BITS-1:0] len, len_nxt;
  logic [LEN_BITS:0]   beat_cnt, beat_nxt;
  logic                rid_sel_unused;

  // R is routed by the registered grant, so the echoed select bits are not needed.
  assign rid_sel_unused = ^RID_S[IDS_BITS-1:IDM_BITS];

  rr_pick #(.NUM_M(NUM_M)) u_pick (
    .req    (ARVALID_M),
    .last   (last_grant),
    .grant  (pick_idx),
    .any_req(pick_any)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= SEL_BITS'(NUM_M - 1);
      len        <= '0;
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_nxt;
      len        <= len_nxt;
      beat_cnt   <= beat_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last_grant;
    len_nxt   = len;
    beat_nxt  = beat_cnt;
    ARREADY_M = '0;
    RID_M     = '0;
    RDATA_M   = '0;
    RRESP_M   = '0;
    RLAST_M   = '0;
    RVALID_M  = '0;
    ARID_S    = '0;
    ARADDR_S  = '0;
    ARLEN_S   = '0;
    ARSIZE_S  = '0;
    ARBURST_S = '0;
    ARVALID_S = 1'b0;
    RREADY_S  = 1'b0;
    LEN_ERR   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt = ADDR;
          grant_nxt = pick_idx;
          len_nxt   = ARLEN_M[pick_idx];
        end
      end
      ADDR: begin
        ARVALID_S        = ARVALID_M[grant];
        ARID_S           = {grant, ARID_M[grant]};
        ARADDR_S         = ARADDR_M[grant];
        ARLEN_S          = ARLEN_M[grant];
        ARSIZE_S         = ARSIZE_M[grant];
        ARBURST_S        = ARBURST_M[grant];
        ARREADY_M[grant] = ARREADY_S;
        if (ARVALID_M[grant] && ARREADY_S) begin
          state_nxt = DATA;
          beat_nxt  = '0;
        end
      end
      DATA: begin
        RVALID_M[grant] = RVALID_S;
        RID_M[grant]    = RID_S[IDM_BITS-1:0];
        RDATA_M[grant]  = RDATA_S;
        RRESP_M[grant]  = RRESP_S;
        RLAST_M[grant]  = RLAST_S;
        RREADY_S        = RREADY_M[grant];
        if (RVALID_S && RREADY_M[grant]) begin
          beat_nxt = beat_cnt + 1'b1;
          LEN_ERR  = (RLAST_S != (beat_cnt == {1'b0, len}));
          // The slave's RLAST, not our count, closes the burst.
          if (RLAST_S) begin
            last_nxt  = grant;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter (NUM_M=4): transaction-level reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_axi_rd_arbiter;
  localparam int NM  = 4;
  localparam int IDM = 4;
  localparam int IDS = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic [NM-1:0][IDM-1:0] arid_m;
  logic [NM-1:0][31:0]    araddr_m;
  logic [NM-1:0][3:0]     arlen_m;
  logic [NM-1:0][2:0]     arsize_m;
  logic [NM-1:0][1:0]     arburst_m;
  logic [NM-1:0]          arvalid_m, arready_m;
  logic [NM-1:0][IDM-1:0] rid_m;
  logic [NM-1:0][31:0]    rdata_m;
  logic [NM-1:0][1:0]     rresp_m;
  logic [NM-1:0]          rlast_m, rvalid_m, rready_m;
  logic [IDS-1:0]         arid_s;
  logic [31:0]            araddr_s;
  logic [3:0]             arlen_s;
  logic [2:0]             arsize_s;
  logic [1:0]             arburst_s;
  logic                   arvalid_s, arready_s;
  logic [IDS-1:0]         rid_s;
  logic [31:0]            rdata_s;
  logic [1:0]             rresp_s;
  logic                   rlast_s, rvalid_s, rready_s, len_err;

  axi_rd_arbiter #(
    .NUM_M(NM), .IDM_BITS(IDM), .ADDR_BITS(32), .DATA_BITS(32), .LEN_BITS(4), .SIZE_BITS(3)
  ) dut (
    .ACLK(clk), .ARESETn(rst_n),
    .ARID_M(arid_m), .ARADDR_M(araddr_m), .ARLEN_M(arlen_m), .ARSIZE_M(arsize_m),
    .ARBURST_M(arburst_m), .ARVALID_M(arvalid_m), .ARREADY_M(arready_m),
    .RID_M(rid_m), .RDATA_M(rdata_m), .RRESP_M(rresp_m), .RLAST_M(rlast_m),
    .RVALID_M(rvalid_m), .RREADY_M(rready_m),
    .ARID_S(arid_s), .ARADDR_S(araddr_s), .ARLEN_S(arlen_s), .ARSIZE_S(arsize_s),
    .ARBURST_S(arburst_s), .ARVALID_S(arvalid_s), .ARREADY_S(arready_s),
    .RID_S(rid_s), .RDATA_S(rdata_s), .RRESP_S(rresp_s), .RLAST_S(rlast_s),
    .RVALID_S(rvalid_s), .RREADY_S(rready_s), .LEN_ERR(len_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_next(input logic [NM-1:0] req, input int last);
    for (int k = 1; k <= NM; k++)
      if (req[(last + k) % NM]) return (last + k) % NM;
    return -1;
  endfunction

  // Reference model: who owns the slave, whether its AR is still pending, beats seen.
  int   m_owner = -1;
  bit   m_ar    = 1'b0;
  int   m_beats = 0;
  int   m_len   = 0;
  int   m_last  = NM - 1;
  int   grant_log[$];
  int   dut_beats[NM];
  int   dut_lenerr = 0;
  logic low_ready_seen = 1'b0;

  logic [NM-1:0]          e_arready_m, e_rlast_m, e_rvalid_m;
  logic [NM-1:0][IDM-1:0] e_rid_m;
  logic [NM-1:0][31:0]    e_rdata_m;
  logic [NM-1:0][1:0]     e_rresp_m;
  logic [IDS-1:0]         e_arid_s;
  logic [31:0]            e_araddr_s;
  logic [3:0]             e_arlen_s;
  logic [2:0]             e_arsize_s;
  logic [1:0]             e_arburst_s;
  logic                   e_arvalid_s, e_rready_s, e_len_err;

  always @(negedge clk) begin
    int o;
    int n;
    logic hs;
    hs = 1'b0;
    o  = m_owner;
    if (!rst_n) begin
      check("rst_arvalid_s", 128'(arvalid_s), 128'(0));
      check("rst_arready_m", 128'(arready_m), 128'(0));
      check("rst_rvalid_m",  128'(rvalid_m),  128'(0));
      check("rst_rready_s",  128'(rready_s),  128'(0));
      check("rst_len_err",   128'(len_err),   128'(0));
      check("rst_arid_s",    128'(arid_s),    128'(0));
      check("rst_rdata_m",   128'(rdata_m),   128'(0));
      m_owner = -1; m_ar = 1'b0; m_beats = 0; m_last = NM - 1;
    end else begin
      e_arready_m = '0; e_rlast_m = '0; e_rvalid_m = '0; e_rid_m = '0;
      e_rdata_m = '0; e_rresp_m = '0; e_arid_s = '0; e_araddr_s = '0;
      e_arlen_s = '0; e_arsize_s = '0; e_arburst_s = '0;
      e_arvalid_s = 1'b0; e_rready_s = 1'b0; e_len_err = 1'b0;
      if (o >= 0 && m_ar) begin
        e_arvalid_s    = arvalid_m[o];
        e_arid_s       = IDS'((o << IDM) + int'(arid_m[o]));
        e_araddr_s     = araddr_m[o];
        e_arlen_s      = arlen_m[o];
        e_arsize_s     = arsize_m[o];
        e_arburst_s    = arburst_m[o];
        e_arready_m[o] = arready_s;
      end else if (o >= 0) begin
        e_rvalid_m[o] = rvalid_s;
        e_rready_s    = rready_m[o];
        e_rid_m[o]    = rid_s[IDM-1:0];
        e_rdata_m[o]  = rdata_s;
        e_rresp_m[o]  = rresp_s;
        e_rlast_m[o]  = rlast_s;
        hs = rvalid_s && rready_m[o];
        if (hs) e_len_err = (rlast_s != (m_beats == m_len));
      end
      check("arvalid_s", 128'(arvalid_s), 128'(e_arvalid_s));
      check("arid_s",    128'(arid_s),    128'(e_arid_s));
      check("araddr_s",  128'(araddr_s),  128'(e_araddr_s));
      check("arlen_s",   128'(arlen_s),   128'(e_arlen_s));
      check("arsize_s",  128'(arsize_s),  128'(e_arsize_s));
      check("arburst_s", 128'(arburst_s), 128'(e_arburst_s));
      check("arready_m", 128'(arready_m), 128'(e_arready_m));
      check("rvalid_m",  128'(rvalid_m),  128'(e_rvalid_m));
      check("rready_s",  128'(rready_s),  128'(e_rready_s));
      check("rid_m",     128'(rid_m),     128'(e_rid_m));
      check("rdata_m",   128'(rdata_m),   128'(e_rdata_m));
      check("rresp_m",   128'(rresp_m),   128'(e_rresp_m));
      check("rlast_m",   128'(rlast_m),   128'(e_rlast_m));
      check("len_err",   128'(len_err),   128'(e_len_err));
      for (int i = 0; i < NM; i++)
        if (rvalid_m[i] && rready_m[i]) dut_beats[i]++;
      if (len_err) dut_lenerr++;
      low_ready_seen = low_ready_seen | (|arready_m[1:0]);
      if (o < 0) begin
        n = rr_next(arvalid_m, m_last);
        if (n >= 0) begin
          m_owner = n; m_ar = 1'b1; m_len = int'(arlen_m[n]);
          grant_log.push_back(n);
        end
      end else if (m_ar) begin
        if (arvalid_m[o] && arready_s) begin m_ar = 1'b0; m_beats = 0; end
      end else if (hs) begin
        m_beats++;
        if (rlast_s) begin m_last = o; m_owner = -1; end
      end
    end
  end

  int lenerr_last = -1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    grant_log.delete();
    for (int i = 0; i < NM; i++) dut_beats[i] = 0;
    dut_lenerr = 0;
    low_ready_seen = 1'b0;
    lenerr_last = -1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    arvalid_m = '0; arready_s = 1'b0; rvalid_s = 1'b0; rlast_s = 1'b0;
    rready_m = '1;
    step(); step();
    rst_n = 1'b1;
    step();
    clear_obs();
  endtask

  // Slave side of one burst; rlast_beat<0 means "end on the granted master's ARLEN".
  task automatic serve_burst(input int rlast_beat, input int stall_beat, output int g);
    int n;
    int last_b;
    logic [IDS-1:0] rid;
    logic [31:0] data;
    arready_s = 1'b1;
    n = 0;
    #1;
    while (!arvalid_s && n < 20) begin @(posedge clk); #2; n++; end
    check("ar_wait", 128'(arvalid_s), 128'(1));
    if (!arvalid_s) begin arready_s = 1'b0; g = -1; return; end
    rid = arid_s;
    g = int'(arid_s[IDS-1:IDM]);
    last_b = (rlast_beat < 0) ? int'(arlen_m[g]) : rlast_beat;
    step();
    arready_s = 1'b0;
    arvalid_m[g] = 1'b0;
    for (int b = 0; b <= last_b; b++) begin
      data = 32'hD000_0000 + 32'(g * 256 + b);
      rvalid_s = 1'b1; rid_s = rid; rdata_s = data; rresp_s = 2'(b); rlast_s = (b == last_b);
      if (b == stall_beat) begin
        rready_m = '0;
        repeat (5) begin
          #1;
          check("stall_rready_s", 128'(rready_s), 128'(0));
          check("stall_rdata_held", 128'(rdata_m[g]), 128'(data));
          check("stall_rvalid_m", 128'(rvalid_m[g]), 128'(1));
          step();
        end
        rready_m = '1;
      end
      n = 0;
      #1;
      while (!rready_s && n < 20) begin @(posedge clk); #2; n++; end
      check("r_wait", 128'(rready_s), 128'(1));
      if (len_err) lenerr_last = b;
      step();
    end
    rvalid_s = 1'b0; rlast_s = 1'b0;
  endtask

  initial begin
    int g;
    int got[4];
    arid_m = '0; araddr_m = '0; arlen_m = '0; arsize_m = '0; arburst_m = '0;
    arvalid_m = '0; rready_m = '1; arready_s = 1'b0;
    rid_s = '0; rdata_s = '0; rresp_s = '0; rlast_s = 1'b0; rvalid_s = 1'b0;
    #2;
    do_reset();

    // Single burst from M0: id 3, addr 0x100, len 3.
    arid_m[0] = 4'd3; araddr_m[0] = 32'h100; arlen_m[0] = 4'd3; arsize_m[0] = 3'd2; arburst_m[0] = 2'd1;
    arvalid_m[0] = 1'b1;
    #1;
    check("s1_latency_idle", 128'(arvalid_s), 128'(0));
    step();
    check("s1_arvalid_s", 128'(arvalid_s), 128'(1));
    check("s1_arid_s", 128'(arid_s), 128'(6'h03));
    check("s1_araddr_s", 128'(araddr_s), 128'(32'h100));
    serve_burst(-1, -1, g);
    check("s1_grant", 128'(g), 128'(0));
    check("s1_m0_beats", 128'(dut_beats[0]), 128'(4));
    check("s1_m1_beats", 128'(dut_beats[1]), 128'(0));
    check("s1_len_err", 128'(dut_lenerr), 128'(0));

    // M0 and M1 competing, each re-requesting after service.
    do_reset();
    arid_m[0] = 4'd1; araddr_m[0] = 32'h200; arlen_m[0] = 4'd1;
    arid_m[1] = 4'd2; araddr_m[1] = 32'h300; arlen_m[1] = 4'd0; arsize_m[1] = 3'd1; arburst_m[1] = 2'd2;
    arvalid_m[1:0] = 2'b11;
    for (int k = 0; k < 4; k++) begin
      serve_burst(-1, -1, g);
      got[k] = g;
      if (g >= 0 && k < 3) arvalid_m[g] = 1'b1;
    end
    arvalid_m = '0;
    check("s2_grant0", 128'(got[0]), 128'(0));
    check("s2_grant1", 128'(got[1]), 128'(1));
    check("s2_grant2", 128'(got[2]), 128'(0));
    check("s2_grant3", 128'(got[3]), 128'(1));
    check("s2_model_grant1", 128'(grant_log[1]), 128'(1));
    check("s2_model_grant2", 128'(grant_log[2]), 128'(0));
    check("s2_m0_beats", 128'(dut_beats[0]), 128'(4));
    check("s2_m1_beats", 128'(dut_beats[1]), 128'(2));
    step(); step();

    // Only M2 and M3 requesting.
    do_reset();
    arid_m[2] = 4'd7; araddr_m[2] = 32'h2000; arlen_m[2] = 4'd1;
    arid_m[3] = 4'd9; araddr_m[3] = 32'h3000; arlen_m[3] = 4'd2;
    arvalid_m[3:2] = 2'b11;
    for (int k = 0; k < 3; k++) begin
      serve_burst(-1, -1, g);
      got[k] = g;
      if (g >= 0 && k < 2) arvalid_m[g] = 1'b1;
    end
    arvalid_m = '0;
    check("s3_grant0", 128'(got[0]), 128'(2));
    check("s3_grant1", 128'(got[1]), 128'(3));
    check("s3_grant2", 128'(got[2]), 128'(2));
    check("s3_model_grant0", 128'(grant_log[0]), 128'(2));
    check("s3_low_arready", 128'(low_ready_seen), 128'(0));
    step(); step();

    // Early RLAST (len 3, last on beat 2), then late RLAST (len 1, last on beat 3).
    do_reset();
    arid_m[1] = 4'd4; araddr_m[1] = 32'h400; arlen_m[1] = 4'd3;
    arvalid_m[1] = 1'b1;
    serve_burst(2, -1, g);
    check("s4_early_beat", 128'(lenerr_last), 128'(2));
    check("s4_early_count", 128'(dut_lenerr), 128'(1));
    arid_m[0] = 4'd6; araddr_m[0] = 32'h440; arlen_m[0] = 4'd1;
    arvalid_m[0] = 1'b1;
    serve_burst(3, -1, g);
    check("s4_after_err_grant", 128'(g), 128'(0));
    check("s4_late_beat", 128'(lenerr_last), 128'(3));
    check("s4_late_count", 128'(dut_lenerr), 128'(3));
    step();

    // Master back-pressure mid-burst.
    do_reset();
    arid_m[1] = 4'd5; araddr_m[1] = 32'h500; arlen_m[1] = 4'd3;
    arvalid_m[1] = 1'b1;
    serve_burst(-1, 1, g);
    check("s5_grant", 128'(g), 128'(1));
    check("s5_m1_beats", 128'(dut_beats[1]), 128'(4));
    check("s5_len_err", 128'(dut_lenerr), 128'(0));
    step();

    // Reset during beat 1 of an M1 burst; M0 must win the next round against M2.
    clear_obs();
    arvalid_m[1] = 1'b1;
    arready_s = 1'b1;
    #1;
    for (int n = 0; n < 20 && !arvalid_s; n++) begin @(posedge clk); #2; end
    check("s6_ar_wait", 128'(arvalid_s), 128'(1));
    step();
    arready_s = 1'b0; arvalid_m[1] = 1'b0;
    rvalid_s = 1'b1; rid_s = 6'h15; rdata_s = 32'hCAFE_0000; rresp_s = 2'd0; rlast_s = 1'b0;
    step();
    rdata_s = 32'hCAFE_0001;
    rst_n = 1'b0;
    #1;
    check("s6_rst_arvalid_s", 128'(arvalid_s), 128'(0));
    check("s6_rst_rvalid_m", 128'(rvalid_m), 128'(0));
    check("s6_rst_rready_s", 128'(rready_s), 128'(0));
    check("s6_rst_rdata_m", 128'(rdata_m), 128'(0));
    step(); step();
    rst_n = 1'b1;
    rlast_s = 1'b1;
    step(); step();
    check("s6_ignored_beats", 128'(dut_beats[1]), 128'(1));
    rvalid_s = 1'b0; rlast_s = 1'b0;
    arid_m[0] = 4'd8; araddr_m[0] = 32'h600; arlen_m[0] = 4'd0;
    arid_m[2] = 4'd2; araddr_m[2] = 32'h700; arlen_m[2] = 4'd0;
    arvalid_m[0] = 1'b1; arvalid_m[2] = 1'b1;
    serve_burst(-1, -1, g);
    arvalid_m = '0;
    check("s6_post_reset_grant", 128'(g), 128'(0));
    step(); step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
